// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control sequencer for the 16-bit multi-cycle CPU. Each instruction
// is stepped through FETCH/DECODE/EXEC/MEM/WB. The state is registered.
// Datapath strobes and mux selects are decoded combinationally from the
// current state and opcode.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high; gates every write/request strobe
//   opcode[3:0]    IR[15:12], valid from DECODE onward
//   mem_ready      memory completes the current mem_read/mem_write this cycle
//   ALUOp[1:0]     00 addr/PC add, 01 BEQ compare, 10 R funct, 11 I opcode
//   alu_src_a      0=PC, 1=reg A
//   alu_src_b[1:0] 00=reg B, 01=const 2, 10=sext imm, 11=sext imm<<1
//   iord           memory address select: 0=PC, 1=ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   ir_write       load IR
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   pc_src[1:0]    00=ALU result, 01=ALUOut, 10=jump target
//   reg_write      register file write
//   reg_dst        1=rd (R-format), 0=rt
//   mem_to_reg     1=memory data, 0=ALUOut
//   illegal        sticky, an undefined opcode was decoded
//   halted         FSM is in HALT
//   state[2:0]     current state, debug
//   retired        saturating retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          opcode,
    input  logic                mem_ready,
    output logic [1:0]          ALUOp,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                illegal,
    output logic                halted,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t cur;
    state_t nxt;
    logic   retire_now;
    logic   set_illegal;

    logic is_r, is_lw, is_sw, is_beq, is_j, is_imm, is_halt, is_legal;

    assign is_r     = (opcode == 4'b0000);
    assign is_lw    = (opcode == 4'b0100);
    assign is_sw    = (opcode == 4'b0101);
    assign is_beq   = (opcode == 4'b0110);
    assign is_j     = (opcode == 4'b0111);
    assign is_imm   = (opcode == 4'b1001) || (opcode == 4'b1010) ||
                      (opcode == 4'b1011) || (opcode == 4'b0010);
    assign is_halt  = (opcode == 4'b1111);
    assign is_legal = is_r || is_lw || is_sw || is_beq || is_j || is_imm || is_halt;

    always_comb begin
        nxt           = cur;
        retire_now    = 1'b0;
        set_illegal   = 1'b0;
        ALUOp         = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;

        case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_b = 2'b11;
                if (is_j) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    retire_now = 1'b1;
                    nxt        = S_FETCH;
                end else if (is_halt) begin
                    retire_now = 1'b1;
                    nxt        = S_HALT;
                end else if (!is_legal) begin
                    set_illegal = 1'b1;
                    nxt         = S_HALT;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (is_r) begin
                    ALUOp = 2'b10;
                    nxt   = S_WB;
                end else if (is_imm) begin
                    alu_src_b = 2'b10;
                    ALUOp     = 2'b11;
                    nxt       = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 2'b10;
                    nxt       = S_MEM;
                end else if (is_beq) begin
                    ALUOp         = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    retire_now    = 1'b1;
                    nxt           = S_FETCH;
                end else begin
                    // Opcode changed under us; abandon the instruction.
                    nxt = S_FETCH;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (is_lw) begin
                    mem_read = 1'b1;
                    if (mem_ready) nxt = S_WB;
                end else if (is_sw) begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        retire_now = 1'b1;
                        nxt        = S_FETCH;
                    end
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                retire_now = 1'b1;
                nxt        = S_FETCH;
            end
            S_HALT: begin
                nxt = S_HALT;
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase

        // Reset aborts the instruction: nothing may be written or requested.
        if (reset) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
            retire_now    = 1'b0;
            set_illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire_now && (retired != {RETIRE_W{1'b1}}))
                retired <= retired + RETIRE_W'(1);
            if (set_illegal)
                illegal <= 1'b1;
        end
    end

    assign state  = cur;
    assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    localparam int RW = 4;
    localparam int SAT = (1 << RW) - 1;
    localparam int F = 0, D = 1, E = 2, M = 3, W = 4, H = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    opcode;
    logic          mem_ready;
    logic [1:0]    ALUOp;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic          iord;
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic          pc_write;
    logic          pc_write_cond;
    logic [1:0]    pc_src;
    logic          reg_write;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          illegal;
    logic          halted;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .halted(halted),
        .state(state), .retired(retired)
    );

    logic [5:0] strb;
    assign strb = {mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write};

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are
    // sampled on the falling edge.
    task automatic drive(input logic r, input logic [3:0] o, input logic m);
        reset = r; opcode = o; mem_ready = m;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] op;
        logic       mr;
        int         st;
        int         aluop;
        logic [5:0] strb;   // mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write
        int         ret;
    } vec_t;

    vec_t tbl[21];

    // Reference model state for the random phase.
    int         path[5];
    int         plen;
    int         idx;
    int         exp_ret;
    bit         exp_ill;
    logic [3:0] cur_op;

    function automatic logic [3:0] pick_op();
        logic [3:0] legal[9];
        logic [3:0] bad[6];
        int r;
        legal = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'h2};
        bad   = '{4'h1, 4'h3, 4'h8, 4'hC, 4'hD, 4'hE};
        r = $urandom_range(0, 39);
        if (r == 0) return 4'hF;
        if (r == 1) return bad[$urandom_range(0, 5)];
        return legal[$urandom_range(0, 8)];
    endfunction

    // Expected state walk of one instruction, from the opcode's class.
    task automatic build_path(input logic [3:0] o);
        case (o)
            4'h0, 4'h9, 4'hA, 4'hB, 4'h2: begin path = '{F, D, E, W, 0}; plen = 4; end
            4'h4:                        begin path = '{F, D, E, M, W}; plen = 5; end
            4'h5:                        begin path = '{F, D, E, M, 0}; plen = 4; end
            4'h6:                        begin path = '{F, D, E, 0, 0}; plen = 3; end
            4'h7:                        begin path = '{F, D, 0, 0, 0}; plen = 2; end
            default:                     begin path = '{F, D, H, 0, 0}; plen = 3; end
        endcase
    endtask

    initial begin
        int rw_count;
        int hcnt;
        int ninstr;
        logic mr;
        int s;
        logic [5:0] es;
        int ea;

        reset = 1'b1; opcode = 4'h0; mem_ready = 1'b0;
        next_cycle();

        // ---------------- table-driven vectors ----------------
        tbl[0]  = '{1'b1, 4'h0, 1'b1, F, 0, 6'b000000, 0};
        tbl[1]  = '{1'b0, 4'h0, 1'b1, F, 0, 6'b101100, 0};
        tbl[2]  = '{1'b0, 4'h0, 1'b1, D, 0, 6'b000000, 0};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, E, 2, 6'b000000, 0};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, W, 0, 6'b000001, 0};
        tbl[5]  = '{1'b0, 4'h6, 1'b1, F, 0, 6'b101100, 1};
        tbl[6]  = '{1'b0, 4'h6, 1'b1, D, 0, 6'b000000, 1};
        tbl[7]  = '{1'b0, 4'h6, 1'b1, E, 1, 6'b000010, 1};
        tbl[8]  = '{1'b0, 4'h7, 1'b0, F, 0, 6'b100000, 2};
        tbl[9]  = '{1'b0, 4'h7, 1'b1, F, 0, 6'b101100, 2};
        tbl[10] = '{1'b0, 4'h7, 1'b1, D, 0, 6'b000100, 2};
        tbl[11] = '{1'b0, 4'hB, 1'b1, F, 0, 6'b101100, 3};
        tbl[12] = '{1'b0, 4'hB, 1'b1, D, 0, 6'b000000, 3};
        tbl[13] = '{1'b0, 4'hB, 1'b1, E, 3, 6'b000000, 3};
        tbl[14] = '{1'b0, 4'hB, 1'b1, W, 0, 6'b000001, 3};
        tbl[15] = '{1'b0, 4'h5, 1'b1, F, 0, 6'b101100, 4};
        tbl[16] = '{1'b0, 4'h5, 1'b1, D, 0, 6'b000000, 4};
        tbl[17] = '{1'b0, 4'h5, 1'b1, E, 0, 6'b000000, 4};
        tbl[18] = '{1'b0, 4'h5, 1'b0, M, 0, 6'b010000, 4};
        tbl[19] = '{1'b1, 4'h5, 1'b1, M, 0, 6'b000000, 4};
        tbl[20] = '{1'b0, 4'h0, 1'b0, F, 0, 6'b100000, 0};

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].mr);
            chk($sformatf("tbl%0d state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d ALUOp", i), ALUOp, tbl[i].aluop);
            chk($sformatf("tbl%0d strobes", i), strb, tbl[i].strb);
            chk($sformatf("tbl%0d retired", i), retired, tbl[i].ret);
            if (tbl[i].st == W)
                chk($sformatf("tbl%0d reg_dst", i), reg_dst, (tbl[i].op == 4'h0) ? 1 : 0);
            if (tbl[i].st == E && tbl[i].op == 4'hB)
                chk($sformatf("tbl%0d alu_src_b", i), alu_src_b, 2);
            if (tbl[i].st == E && tbl[i].op == 4'h6)
                chk($sformatf("tbl%0d pc_src", i), pc_src, 1);
            next_cycle();
        end

        // ---------------- LW with three stall cycles in MEM ----------------
        rw_count = 0;
        drive(1'b0, 4'h4, 1'b1); chk("lw fetch state", state, F); next_cycle();
        drive(1'b0, 4'h4, 1'b1); chk("lw decode state", state, D); next_cycle();
        drive(1'b0, 4'h4, 1'b1);
        chk("lw exec state", state, E);
        chk("lw exec alu_src_b", alu_src_b, 2);
        chk("lw exec ALUOp", ALUOp, 0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'h4, (k == 3));
            chk($sformatf("lw mem%0d state", k), state, M);
            chk($sformatf("lw mem%0d mem_read", k), mem_read, 1);
            chk($sformatf("lw mem%0d iord", k), iord, 1);
            chk($sformatf("lw mem%0d reg_write", k), reg_write, 0);
            next_cycle();
        end
        drive(1'b0, 4'h4, 1'b1);
        chk("lw wb state", state, W);
        chk("lw wb reg_write", reg_write, 1);
        chk("lw wb mem_to_reg", mem_to_reg, 1);
        chk("lw wb reg_dst", reg_dst, 0);
        chk("lw wb retired", retired, 0);
        next_cycle();
        drive(1'b0, 4'h0, 1'b0);
        chk("lw done state", state, F);
        chk("lw done reg_write", reg_write, 0);
        chk("lw done retired", retired, 1);
        next_cycle();

        // ---------------- illegal opcode, sticky halt ----------------
        drive(1'b0, 4'hC, 1'b1); next_cycle();
        drive(1'b0, 4'hC, 1'b1); chk("ill decode state", state, D); next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'hC, 1'b1);
            chk($sformatf("ill h%0d state", k), state, H);
            chk($sformatf("ill h%0d halted", k), halted, 1);
            chk($sformatf("ill h%0d illegal", k), illegal, 1);
            chk($sformatf("ill h%0d strobes", k), strb, 0);
            chk($sformatf("ill h%0d retired", k), retired, 1);
            next_cycle();
        end
        drive(1'b1, 4'h0, 1'b1); chk("ill reset strobes", strb, 0); next_cycle();
        drive(1'b0, 4'h0, 1'b0);
        chk("ill after reset state", state, F);
        chk("ill after reset illegal", illegal, 0);
        chk("ill after reset halted", halted, 0);
        chk("ill after reset retired", retired, 0);
        next_cycle();

        // ---------------- saturation: 17 jumps into a 4-bit counter ----------------
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 4'h7, 1'b1); next_cycle();
            drive(1'b0, 4'h7, 1'b1); next_cycle();
        end
        drive(1'b0, 4'h7, 1'b0);
        chk("saturate retired", retired, SAT);
        chk("saturate state", state, F);
        next_cycle();

        // ---------------- randomized run against the reference model ----------------
        drive(1'b1, 4'h0, 1'b0); next_cycle();
        exp_ret = 0; exp_ill = 0; hcnt = 0; ninstr = 0;
        cur_op = pick_op(); build_path(cur_op); idx = 0;
        for (int cyc = 0; cyc < 4000 && ninstr < 300; cyc++) begin
            s  = path[idx];
            mr = ($urandom_range(0, 3) != 0);
            if (s == H && hcnt == 3) begin
                drive(1'b1, cur_op, mr);
                chk("rnd reset strobes", strb, 0);
                next_cycle();
                exp_ret = 0; exp_ill = 0; hcnt = 0;
                cur_op = pick_op(); build_path(cur_op); idx = 0; ninstr++;
                continue;
            end
            es = '0; ea = 0;
            case (s)
                F: es = {1'b1, 1'b0, mr, mr, 1'b0, 1'b0};
                D: es[2] = (cur_op == 4'h7);
                E: begin
                    es[1] = (cur_op == 4'h6);
                    if (cur_op == 4'h0) ea = 2;
                    else if (cur_op == 4'h6) ea = 1;
                    else if (cur_op == 4'h4 || cur_op == 4'h5) ea = 0;
                    else ea = 3;
                end
                M: begin
                    es[5] = (cur_op == 4'h4);
                    es[4] = (cur_op == 4'h5);
                end
                W: es[0] = 1'b1;
                default: es = '0;
            endcase
            drive(1'b0, cur_op, mr);
            chk("rnd state", state, s);
            chk("rnd strobes", strb, es);
            chk("rnd retired", retired, exp_ret);
            chk("rnd illegal", illegal, exp_ill);
            chk("rnd halted", halted, (s == H) ? 1 : 0);
            if (s == E) chk("rnd ALUOp", ALUOp, ea);
            if (s == M) chk("rnd iord", iord, 1);
            if (s == W) begin
                chk("rnd reg_dst", reg_dst, (cur_op == 4'h0) ? 1 : 0);
                chk("rnd mem_to_reg", mem_to_reg, (cur_op == 4'h4) ? 1 : 0);
            end
            next_cycle();
            // Advance the model across the edge just taken.
            if (s == H) begin
                hcnt++;
            end else if ((s == F || s == M) && !mr) begin
                // memory stall
            end else begin
                if (s == D && cur_op == 4'hF && exp_ret < SAT) exp_ret++;
                if (s == D && path[2] == H && cur_op != 4'hF) exp_ill = 1;
                if (idx == plen - 1) begin
                    if (exp_ret < SAT) exp_ret++;
                    cur_op = pick_op(); build_path(cur_op); idx = 0; ninstr++;
                end else begin
                    idx++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
